mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the data-memory requester (MEM stage).
- Sequences one outstanding transaction at a time over a valid/accept/response handshake with variable latency.
- Returns stall requests that the pipeline hazard logic ORs into its fetch and memory-stage stall terms.
- Data requests normally win; a starvation counter guarantees that fetch makes progress.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits; 0 = strict data priority. Range 0-15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word; valid when if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held with all d_* inputs stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_addr_mode  in  3  access size/sign code (byte/half/word, signed/unsigned); forwarded unmodified.
- d_rdata  out  DATA_WIDTH  load data; valid when d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  transaction valid to memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_addr_mode  out  3  forwarded d_addr_mode; 3'b010 (word) for fetches.
- mem_gnt  in  1  memory accepts the transaction this cycle.
- mem_rvalid  in  1  completion/read data valid; arrives at least 1 cycle after mem_gnt, also for writes.
- mem_rdata  in  DATA_WIDTH  read data.
- stall_if  out  1  fetch stall request.
- stall_mem  out  1  MEM-stage stall request.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. A registered owner bit (I/D) selects which requester the transaction belongs to.
- IDLE:
  - Both requests pending: pick D, unless the starve counter equals STARVE_LIMIT and STARVE_LIMIT≠0, then pick I.
  - Only one request pending: pick it.
  - Latch the owner and all request fields into transaction registers, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_req=1 and mem_* driven from the transaction registers.
  - mem_gnt=1: go to WAIT. Otherwise hold, with outputs stable.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: latch mem_rdata into the owner's rdata register, go to RESP. For a write, the rdata register is left unchanged.
- RESP:
  - The owner's ready output = 1 for exactly this cycle, then go to IDLE.
  - Owner re-requesting in the next cycle is legal and re-arbitrates normally.
- Minimum latency: request seen in cycle 0 → ISSUE in cycle 1 (gnt) → rvalid in cycle 2 → ready in cycle 3.
- Starve counter (4 bits):
  - +1 on each D pick while if_req=1.
  - Cleared on an I pick, or on a D pick with if_req=0.
  - Saturates at STARVE_LIMIT.
- Stall outputs are combinational:
  - stall_if = if_req & ~if_ready.
  - stall_mem = d_req & ~d_ready.
- if_rdata and d_rdata hold their last value until overwritten.
- mem_rvalid outside WAIT is ignored. mem_gnt outside ISSUE is ignored.
- Deasserting a req before its ready pulse is illegal; the bench flags it with an assertion. The RTL completes the transaction anyway and still pulses ready.
- Reset values (any cycle, including mid-transaction):
  - State → IDLE; owner → D.
  - mem_req, mem_we, if_ready, d_ready = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_addr_mode = 3'b000; starve counter = 0.
  - A late mem_rvalid after reset is ignored.
- No address arithmetic: addresses pass through unchanged; alignment is the memory's responsibility.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner enum (OWN_I/OWN_D);
  - the addr-mode codes, including ADDR_MODE_WORD = 3'b010, shared with the datapath's load/store unit.
- One sub-module, mem_arb_pick:
  - combinational pick from if_req, d_req and the starve counter;
  - sequential starve counter update on each IDLE→ISSUE transition.
- Top level holds the FSM, transaction registers and response registers.

Test Plan:
- Single fetch: if_req, if_addr=0x100; gnt in ISSUE cycle; rvalid 2 cycles later with rdata=0xDEADBEEF → mem_req asserted cycles 1-1; if_ready pulses once, if_rdata=0xDEADBEEF; stall_if=1 until the pulse.
- Simultaneous requests: if_req and d_req (load, 0x2000, mode 3'b000) both in cycle 0 → data issued first with mem_addr_mode=3'b000; fetch issued after d_ready, with mode 3'b010.
- Starvation, STARVE_LIMIT=4: if_req held while d_req is re-asserted back-to-back → exactly 4 data grants, then the fetch is granted; counter reads 0 afterwards.
- Backpressure: mem_gnt held low for 5 cycles in ISSUE → mem_req, mem_addr and mem_wdata stay constant for all 6 cycles; single transaction seen by memory.
- Store, d_we=1, d_wdata=0x12345678 → mem_we=1, d_ready pulses after rvalid, d_rdata unchanged from its previous value.
- Reset in WAIT, then late rvalid → state IDLE, all outputs at reset values, no ready pulse; next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states,
// transaction owner encoding and the load/store access-size codes.
package mem_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  // Which requester the in-flight transaction belongs to.
  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  // Access size/sign codes, shared with the load/store unit.
  typedef enum logic [2:0] {
    ADDR_MODE_BYTE   = 3'b000,
    ADDR_MODE_HALF   = 3'b001,
    ADDR_MODE_WORD   = 3'b010,
    ADDR_MODE_BYTE_U = 3'b100,
    ADDR_MODE_HALF_U = 3'b101
  } addr_mode_e;

  // Width of the fetch starvation counter.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection for the memory port arbiter. Data normally wins;
// once STARVE_LIMIT data grants have gone by with a fetch waiting, the
// fetch is picked instead. STARVE_LIMIT = 0 gives strict data priority.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   pick_en,
  output logic   pick_valid,
  output owner_e pick_owner
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    starve_hit;

  // Combinational owner choice from the pending requests and the counter.
  always_comb begin
    pick_valid = if_req | d_req;
    starve_hit = (LIMIT != '0) && (starve_q == LIMIT);
    if (if_req && (!d_req || starve_hit)) pick_owner = OWN_I;
    else                                  pick_owner = OWN_D;
  end

  // Counter update, applied only when the sequencer commits a pick.
  always_comb begin
    starve_d = starve_q;
    if (pick_en) begin
      if (pick_owner == OWN_D && if_req) begin
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and
// the MEM stage. One transaction in flight at a time over a
// valid/accept/response handshake; stall requests feed hazard logic.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_addr_mode,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_addr_mode,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  pick_valid;
  logic                  pick_en;
  owner_e                pick_owner;

  assign pick_en = (state_q == S_IDLE) && pick_valid;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .d_req      (d_req),
    .pick_en    (pick_en),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Sequencer next state, transaction capture and response capture.
  always_comb begin
    // NOTE: every variable starts from its held value so no branch can leave
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          state_d = S_ISSUE;
          if (pick_owner == OWN_I) begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            mode_d  = ADDR_MODE_WORD;
          end else begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            mode_d  = d_addr_mode;
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          // Stores complete without touching the load-data register.
          if (owner_q == OWN_I) if_rdata_d = mem_rdata;
          else if (!we_q)       d_rdata_d  = mem_rdata;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All sequencer, transaction and response registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values, independent
    // of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= 3'b000;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory side: fields come straight from the transaction registers so
  // they stay stable through any amount of grant backpressure.
  assign mem_req       = (state_q == S_ISSUE);
  assign mem_we        = mem_req & we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_addr_mode = mode_q;

  // Requester side.
  assign if_ready  = (state_q == S_RESP) && (owner_q == OWN_I);
  assign d_ready   = (state_q == S_RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for the basic flows,
// then hand-written starvation, backpressure and reset-in-WAIT sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_addr_mode;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_addr_mode;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_tests = 0;
  int n_fail  = 0;

  logic auto_mem = 1'b0;
  logic gnt_last = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_mode(d_addr_mode), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_mode(mem_addr_mode), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Protocol rule: a pending request must stay up until its ready pulse.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_ready) |=> if_req) else $error("if_req dropped before if_ready");
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_ready) |=> d_req) else $error("d_req dropped before d_ready");

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_mode;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic        chk_bus;
    logic        e_we;
    logic [31:0] e_addr;
    logic [2:0]  e_mode;
    logic        e_if_ready;
    logic        e_d_ready;
    logic        e_stall_if;
    logic        e_stall_mem;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] dm,
    input logic g, input logic rv, input logic [31:0] rd,
    input logic er, input logic ec, input logic ew, input logic [31:0] ea,
    input logic [2:0] em, input logic eir, input logic edr, input logic esi,
    input logic esm, input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.d_mode = dm; v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.chk_bus = ec; v.e_we = ew; v.e_addr = ea; v.e_mode = em;
    v.e_if_ready = eir; v.e_d_ready = edr; v.e_stall_if = esi; v.e_stall_mem = esm;
    v.e_if_rdata = eird; v.e_d_rdata = edrd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock; when the auto responder is on it grants every request at
  // once and returns rvalid on the following cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rvalid = gnt_last;
      gnt_last   = mem_req;
      mem_gnt    = mem_req;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_req"},   mem_req, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_mode"},  mem_addr_mode, 0);
    check({tag, "_if_ready"},  if_ready, 0);
    check({tag, "_d_ready"},   d_ready, 0);
    check({tag, "_if_rdata"},  if_rdata, 0);
    check({tag, "_d_rdata"},   d_rdata, 0);
    check({tag, "_stall_if"},  stall_if, 0);
    check({tag, "_stall_mem"}, stall_mem, 0);
    check({tag, "_starve"},    dut.u_pick.starve_q, 0);
  endtask

  task automatic wait_if_ready(input string name, input int budget);
    int n = 0;
    while (!if_ready && n < budget) begin tick(); n++; end
    check({name, "_if_ready_timeout"}, if_ready, 1);
  endtask

  task automatic wait_d_ready(input string name, input int budget);
    int n = 0;
    while (!d_ready && n < budget) begin tick(); n++; end
    check({name, "_d_ready_timeout"}, d_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dgr, fetch_seen, n, stable, hs, extra;
    logic [31:0] a0, w0;

    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_addr_mode = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // ifr ifa     dr dw da        dwd          dm     g  rv rdata          | req chk we addr      mode   ir dr si sm if_rdata      d_rdata
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'b000, 1, 0, 0,              1, 1, 0, 32'h100, 3'b010,    0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'b000, 0, 1, 32'hDEADBEEF,   0, 0, 0, 0, 0,               0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               1, 0, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0,       0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 0, 0, 32'hDEADBEEF, 0));
    // Simultaneous fetch and load: data first, fetch after d_ready.
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 0, 3'b000, 0, 0, 0,       0, 0, 0, 0, 0,               0, 0, 1, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 0, 3'b000, 1, 0, 0,       1, 1, 0, 32'h2000, 3'b000,   0, 0, 1, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 0, 3'b000, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0,          0, 0, 1, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 0, 3'b000, 0, 0, 0,       0, 0, 0, 0, 0,               0, 1, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 3'b000, 1, 0, 0,              1, 1, 0, 32'h104, 3'b010,    0, 0, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 3'b000, 0, 1, 32'h11112222,   0, 0, 0, 0, 0,               0, 0, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               1, 0, 0, 0, 32'h11112222, 32'hCAFEF00D));
    // Stray gnt/rvalid in IDLE must be ignored.
    vecs.push_back(mk(0, 0,       0, 0, 0, 0, 3'b000, 1, 1, 32'hFFFFFFFF,   0, 0, 0, 0, 0,               0, 0, 0, 0, 32'h11112222, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0,       0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 0, 0, 32'h11112222, 32'hCAFEF00D));
    // Store: d_rdata keeps its previous load value.
    vecs.push_back(mk(0, 0, 1, 1, 32'h3000, 32'h12345678, 3'b010, 0, 0, 0,  0, 0, 0, 0, 0,               0, 0, 0, 1, 32'h11112222, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 1, 1, 32'h3000, 32'h12345678, 3'b010, 1, 0, 0,  1, 1, 1, 32'h3000, 3'b010,   0, 0, 0, 1, 32'h11112222, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 1, 1, 32'h3000, 32'h12345678, 3'b010, 0, 1, 32'hBADBADBA, 0, 0, 0, 0, 0,     0, 0, 0, 1, 32'h11112222, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 1, 1, 32'h3000, 32'h12345678, 3'b010, 0, 0, 0,  0, 0, 0, 0, 0,               0, 1, 0, 0, 32'h11112222, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0,       0, 0, 0, 0, 3'b000, 0, 0, 0,              0, 0, 0, 0, 0,               0, 0, 0, 0, 32'h11112222, 32'hCAFEF00D));

    foreach (vecs[i]) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; d_req = vecs[i].d_req;
      d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      d_addr_mode = vecs[i].d_mode; mem_gnt = vecs[i].gnt;
      mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      #4;
      check($sformatf("v%0d_mem_req", i),   mem_req,   vecs[i].e_req);
      check($sformatf("v%0d_if_ready", i),  if_ready,  vecs[i].e_if_ready);
      check($sformatf("v%0d_d_ready", i),   d_ready,   vecs[i].e_d_ready);
      check($sformatf("v%0d_stall_if", i),  stall_if,  vecs[i].e_stall_if);
      check($sformatf("v%0d_stall_mem", i), stall_mem, vecs[i].e_stall_mem);
      check($sformatf("v%0d_if_rdata", i),  if_rdata,  vecs[i].e_if_rdata);
      check($sformatf("v%0d_d_rdata", i),   d_rdata,   vecs[i].e_d_rdata);
      if (vecs[i].chk_bus) begin
        check($sformatf("v%0d_mem_we", i),   mem_we,        vecs[i].e_we);
        check($sformatf("v%0d_mem_addr", i), mem_addr,      vecs[i].e_addr);
        check($sformatf("v%0d_mem_mode", i), mem_addr_mode, vecs[i].e_mode);
      end
      tick();
    end
    mem_gnt = 0; mem_rvalid = 0;

    // Starvation: fetch held, loads re-requested back to back.
    if_addr = 32'h200; d_addr = 32'h7000; d_we = 0; d_addr_mode = 3'b010;
    mem_rdata = 32'h600DF00D; if_req = 1; d_req = 1;
    auto_mem = 1; gnt_last = 0;
    dgr = 0; fetch_seen = 0;
    for (int k = 0; k < 80 && fetch_seen == 0; k++) begin
      tick();
      if (mem_req && mem_gnt) begin
        if (mem_addr == 32'h7000) dgr++;
        else begin
          fetch_seen = 1;
          check("starve_fetch_addr", mem_addr, 32'h200);
          check("starve_cnt_after_fetch", dut.u_pick.starve_q, 0);
        end
      end
    end
    check("starve_fetch_seen", fetch_seen, 1);
    check("starve_data_grants", dgr, 4);
    wait_if_ready("starve", 20);
    check("starve_if_rdata", if_rdata, 32'h600DF00D);
    tick();
    if_req = 0;
    wait_d_ready("starve_tail", 20);
    tick();
    d_req = 0;
    auto_mem = 0; gnt_last = 0; mem_gnt = 0; mem_rvalid = 0;
    tick();

    // Backpressure: gnt low for 5 ISSUE cycles, granted on the 6th.
    d_req = 1; d_we = 1; d_addr = 32'h6000; d_wdata = 32'hA5A5A5A5; d_addr_mode = 3'b001;
    n = 0;
    do begin tick(); n++; end while (!mem_req && n < 10);
    check("bp_issue_seen", mem_req, 1);
    a0 = mem_addr; w0 = mem_wdata; stable = 1; hs = 0;
    for (int i = 1; i < 6; i++) begin
      tick();
      if (mem_req && mem_addr == a0 && mem_wdata == w0) stable++;
      if (i == 5) begin
        mem_gnt = 1;
        if (mem_req) hs++;
      end
    end
    check("bp_stable_cycles", stable, 6);
    check("bp_mem_addr", mem_addr, 32'h6000);
    check("bp_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    check("bp_mem_we", mem_we, 1);
    check("bp_mem_mode", mem_addr_mode, 3'b001);
    tick();
    mem_gnt = 0;
    check("bp_req_after_gnt", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 32'h77777777;
    tick();
    mem_rvalid = 0;
    check("bp_d_ready", d_ready, 1);
    check("bp_store_keeps_d_rdata", d_rdata, 32'h600DF00D);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) d_req = 0;
      if (mem_req) extra++;
    end
    check("bp_single_handshake", hs + extra, 1);

    // Reset in WAIT, then a late rvalid that must be ignored.
    d_req = 1; d_we = 0; d_addr = 32'h4000; d_addr_mode = 3'b100;
    tick();
    check("rw_issue", mem_req, 1);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    check("rw_in_wait", mem_req, 0);
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h55555555;
    check_reset_state("rw");
    tick();
    mem_rvalid = 0;
    check("rw_late_no_ready", d_ready, 0);
    check("rw_late_d_rdata", d_rdata, 0);
    check("rw_late_no_req", mem_req, 0);
    tick();
    check("rw_late_no_ready2", d_ready, 0);
    if_req = 1; if_addr = 32'h500; mem_rdata = 32'h0A0B0C0D;
    auto_mem = 1; gnt_last = 0;
    wait_if_ready("rw_next", 20);
    check("rw_next_if_rdata", if_rdata, 32'h0A0B0C0D);
    tick();
    if_req = 0;
    auto_mem = 0; mem_gnt = 0; mem_rvalid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
